// File: rtl/mod_burst_sequencer.sv
// -----------------------------------------------------------------------------
// mod_burst_sequencer
//
// Sequences the carrier modulator of the test harness. A burst configuration
// from the UART command decoder is accepted through a valid/ready handshake.
// The sequencer then drives the modulator's half-period field, its reset and
// its data gate so that it produces cfg_count bursts. Each burst is
// cfg_on_len cycles long, and consecutive bursts are separated by cfg_off_len
// idle cycles. A one-cycle done pulse marks completion.
//
// Parameters
//   CPHP_W  width of the carrier cycles-per-half-period field
//   LEN_W   width of the on/off length counters (clk cycles)
//   CNT_W   width of the burst-count field
//
// Ports
//   clk          system clock
//   n_reset      asynchronous active-low reset
//   cfg_valid    configuration offered
//   cfg_ready    sequencer idle and able to accept a configuration (comb.)
//   cfg_cphp     carrier cycles per half period
//   cfg_on_len   burst on-time in cycles
//   cfg_off_len  gap between bursts in cycles
//   cfg_count    number of bursts
//   abort        synchronous abort request (honoured in LOAD/BURST/GAP)
//   mod_cphp     half-period value held for the modulator
//   mod_n_reset  synchronous active-low reset to the modulator
//   mod_in       data gate to the modulator
//   busy         sequence in progress
//   done         one-cycle pulse on normal completion
//   aborted      one-cycle pulse when a sequence is terminated by abort
//
// Build option
//   MOD_BURST_SEQ_REPEAT_EN  when defined, cfg_count == 0 repeats the
//                            burst/gap pattern until abort. When it is
//                            undefined, cfg_count == 0 completes at once.
// -----------------------------------------------------------------------------
module mod_burst_sequencer #(
  parameter int CPHP_W = 16,
  parameter int LEN_W  = 24,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CPHP_W-1:0] cfg_cphp,
  input  logic [LEN_W-1:0]  cfg_on_len,
  input  logic [LEN_W-1:0]  cfg_off_len,
  input  logic [CNT_W-1:0]  cfg_count,
  input  logic              abort,
  output logic [CPHP_W-1:0] mod_cphp,
  output logic              mod_n_reset,
  output logic              mod_in,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_BURST,
    S_GAP,
    S_FIN
  } state_t;

  localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t             r_state;
  logic [LEN_W-1:0]   r_on_len;
  logic [LEN_W-1:0]   r_off_len;
  logic [CNT_W-1:0]   r_count;
  logic [LEN_W-1:0]   r_on_cnt;
  logic [LEN_W-1:0]   r_off_cnt;
  logic [CNT_W-1:0]   r_bursts_left;
  logic               r_repeat;

  logic               w_accept;
  logic               w_abort;
  logic               w_cfg_repeat;
  logic               w_cfg_empty;

  assign cfg_ready = (r_state == S_IDLE);
  assign w_accept  = cfg_valid && cfg_ready;

  // Abort only matters while a sequence is actually running. In IDLE and FIN
  // it is ignored, so an abort on the accept edge and an abort during the
  // done cycle both have no effect.
  assign w_abort = abort && ((r_state == S_LOAD) || (r_state == S_BURST) ||
                             (r_state == S_GAP));

`ifdef MOD_BURST_SEQ_REPEAT_EN
  // A zero count selects endless repetition instead of an empty sequence.
  assign w_cfg_repeat = (cfg_count == '0);
`else
  assign w_cfg_repeat = 1'b0;
`endif

  // An empty sequence skips LOAD and goes straight to the done cycle.
  assign w_cfg_empty = (cfg_on_len == '0) || ((cfg_count == '0) && !w_cfg_repeat);

  // The next-state logic and the registered outputs live in one clocked
  // process. Each transition writes the output values that belong to the
  // state being entered, so every output is a flop with no decode glitches.
  // NOTE: all state below is updated with non-blocking assignments, so every
  // branch reads the values from before this edge. Counter comparisons such
  // as r_on_cnt == 1 therefore see the count of the current cycle.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state       <= S_IDLE;
      r_on_len      <= '0;
      r_off_len     <= '0;
      r_count       <= '0;
      r_on_cnt      <= '0;
      r_off_cnt     <= '0;
      r_bursts_left <= '0;
      r_repeat      <= 1'b0;
      mod_cphp      <= '0;
      mod_n_reset   <= 1'b0;
      mod_in        <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      aborted       <= 1'b0;
    end else begin
      // The completion pulses are asserted only on the transition that
      // produces them, so they last exactly one cycle.
      done    <= 1'b0;
      aborted <= 1'b0;

      if (w_abort) begin
        r_state     <= S_IDLE;
        aborted     <= 1'b1;
        mod_in      <= 1'b0;
        mod_n_reset <= 1'b0;
        busy        <= 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            mod_n_reset <= 1'b0;
            mod_in      <= 1'b0;
            busy        <= 1'b0;
            if (w_accept) begin
              mod_cphp  <= cfg_cphp;
              r_on_len  <= cfg_on_len;
              r_off_len <= cfg_off_len;
              r_count   <= cfg_count;
              r_repeat  <= w_cfg_repeat;
              if (w_cfg_empty) begin
                r_state <= S_FIN;
                done    <= 1'b1;
              end else begin
                // The modulator stays in reset through LOAD, so its carrier
                // phase starts cleanly with the first burst.
                r_state <= S_LOAD;
                busy    <= 1'b1;
              end
            end
          end

          S_LOAD: begin
            r_on_cnt      <= r_on_len;
            r_bursts_left <= r_count;
            r_state       <= S_BURST;
            mod_n_reset   <= 1'b1;
            mod_in        <= 1'b1;
            busy          <= 1'b1;
          end

          S_BURST: begin
            if (r_on_cnt == LEN_ONE) begin
              // Last on-cycle of this burst. In repeat mode bursts_left is
              // frozen, so the final-burst test below never fires.
              if (!r_repeat) begin
                r_bursts_left <= r_bursts_left - CNT_ONE;
              end
              if (!r_repeat && (r_bursts_left == CNT_ONE)) begin
                r_state     <= S_FIN;
                done        <= 1'b1;
                mod_in      <= 1'b0;
                mod_n_reset <= 1'b0;
                busy        <= 1'b0;
              end else if (r_off_len == '0) begin
                // Back-to-back bursts: mod_in is simply left high, so the
                // gate shows no low glitch between bursts.
                r_on_cnt <= r_on_len;
              end else begin
                r_off_cnt <= r_off_len;
                r_state   <= S_GAP;
                mod_in    <= 1'b0;
              end
            end else begin
              r_on_cnt <= r_on_cnt - LEN_ONE;
            end
          end

          S_GAP: begin
            if (r_off_cnt == LEN_ONE) begin
              // The carrier keeps running through the gap. Only the data
              // gate is raised again here.
              r_on_cnt <= r_on_len;
              r_state  <= S_BURST;
              mod_in   <= 1'b1;
            end else begin
              r_off_cnt <= r_off_cnt - LEN_ONE;
            end
          end

          S_FIN: begin
            r_state     <= S_IDLE;
            mod_in      <= 1'b0;
            mod_n_reset <= 1'b0;
            busy        <= 1'b0;
          end

          default: begin
            r_state     <= S_IDLE;
            mod_in      <= 1'b0;
            mod_n_reset <= 1'b0;
            busy        <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mod_burst_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mod_burst_sequencer
//
// Scoreboard bench for mod_burst_sequencer. Each stimulus call pushes the
// cycle-by-cycle output trace expected while the block is active (busy, done
// or aborted high). A monitor on the falling edge pops one entry for every
// active cycle and compares it with the DUT outputs. In idle cycles it checks
// that the modulator gate and reset stay low and that cfg_ready is high.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mod_burst_sequencer;

  localparam int CPHP_W = 16;
  localparam int LEN_W  = 24;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              n_reset = 1'b0;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [CPHP_W-1:0] cfg_cphp = '0;
  logic [LEN_W-1:0]  cfg_on_len = '0;
  logic [LEN_W-1:0]  cfg_off_len = '0;
  logic [CNT_W-1:0]  cfg_count = '0;
  logic              abort = 1'b0;
  logic [CPHP_W-1:0] mod_cphp;
  logic              mod_n_reset;
  logic              mod_in;
  logic              busy;
  logic              done;
  logic              aborted;

  mod_burst_sequencer #(
    .CPHP_W(CPHP_W),
    .LEN_W (LEN_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .n_reset    (n_reset),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_cphp   (cfg_cphp),
    .cfg_on_len (cfg_on_len),
    .cfg_off_len(cfg_off_len),
    .cfg_count  (cfg_count),
    .abort      (abort),
    .mod_cphp   (mod_cphp),
    .mod_n_reset(mod_n_reset),
    .mod_in     (mod_in),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CPHP_W-1:0] cphp;
    logic              mod_in;
    logic              mod_n_reset;
    logic              busy;
    logic              done;
    logic              aborted;
    logic              cfg_ready;
  } obs_t;

  obs_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   busy_cycles = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic obs_t rec(input logic [CPHP_W-1:0] c, input logic i, input logic nr,
                               input logic b, input logic d, input logic a, input logic r);
    obs_t o;
    o.cphp = c; o.mod_in = i; o.mod_n_reset = nr;
    o.busy = b; o.done = d; o.aborted = a; o.cfg_ready = r;
    return o;
  endfunction

  // Expected trace: LOAD, then on_len burst cycles and off_len gap cycles
  // repeated, then the done cycle. When stop_after >= 0, the trace is cut
  // after that many active cycles and ends with an aborted cycle instead.
  task automatic push_seq(input logic [CPHP_W-1:0] c, input int on, input int off,
                          input int cnt, input int stop_after);
    int n;
    bit rep;
    n   = 0;
    rep = 1'b0;
`ifdef MOD_BURST_SEQ_REPEAT_EN
    rep = (cnt == 0);
`endif
    if (on == 0 || (cnt == 0 && !rep)) begin
      sb.push_back(rec(c, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
      return;
    end
    sb.push_back(rec(c, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    n = 1;
    if (n == stop_after) begin
      sb.push_back(rec(c, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
      return;
    end
    for (int b = 0; rep || b < cnt; b++) begin
      for (int i = 0; i < on; i++) begin
        sb.push_back(rec(c, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
        n++;
        if (n == stop_after) begin
          sb.push_back(rec(c, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
          return;
        end
      end
      if (!rep && b == cnt - 1) break;
      for (int i = 0; i < off; i++) begin
        sb.push_back(rec(c, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
        n++;
        if (n == stop_after) begin
          sb.push_back(rec(c, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
          return;
        end
      end
    end
    sb.push_back(rec(c, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
  endtask

  // Monitor: one scoreboard entry per active cycle.
  always @(negedge clk) begin
    obs_t a;
    obs_t e;
    if (n_reset) begin
      a = rec(mod_cphp, mod_in, mod_n_reset, busy, done, aborted, cfg_ready);
      if (busy) busy_cycles++;
      if (busy || done || aborted) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %h expected no activity at %0t", a, $time);
        end else begin
          e = sb.pop_front();
          check("output_trace", {10'b0, a}, {10'b0, e});
        end
      end else begin
        check("idle_outputs", {29'b0, mod_in, mod_n_reset, cfg_ready}, 32'h1);
      end
    end
  end

  // Waits until cfg_ready is high, pushes the expected trace and then offers
  // the configuration for exactly one edge. Returns 1 ns after the accept edge.
  task automatic apply_cfg(input logic [CPHP_W-1:0] c, input int on, input int off,
                           input int cnt, input int stop_after);
    int k;
    k = 0;
    while (!cfg_ready && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check("cfg_ready_before_accept", {31'b0, cfg_ready}, 32'h1);
    push_seq(c, on, off, cnt, stop_after);
    cfg_cphp    = c;
    cfg_on_len  = LEN_W'(on);
    cfg_off_len = LEN_W'(off);
    cfg_count   = CNT_W'(cnt);
    cfg_valid   = 1'b1;
    @(posedge clk); #1;
    cfg_valid   = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int limit);
    int k;
    k = 0;
    while (sb.size() != 0 && k < limit) begin
      @(negedge clk);
      k++;
    end
    check(name, sb.size(), 32'd0);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state, held across a clock edge.
    #12;
    check("reset_outputs", {10'b0, rec(mod_cphp, mod_in, mod_n_reset, busy, done, aborted, 1'b0)}, 32'h0);
    n_reset = 1'b1;
    #1;
    check("reset_cfg_ready", {31'b0, cfg_ready}, 32'h1);

    // 1: three bursts of 10 on / 4 off. Busy should last 1 + 30 + 8 = 39 cycles.
    busy_cycles = 0;
    apply_cfg(16'd5, 10, 4, 3, -1);
    wait_drain("drain_basic", 200);
    check("busy_cycles_basic", busy_cycles, 32'd39);

    // 2: no gap. mod_in should stay high for 12 cycles; busy lasts 13 cycles.
    busy_cycles = 0;
    apply_cfg(16'd7, 6, 0, 2, -1);
    wait_drain("drain_no_gap", 200);
    check("busy_cycles_no_gap", busy_cycles, 32'd13);

    // 3: abort in the 2nd GAP cycle, then a new configuration accepted at once.
    apply_cfg(16'd5, 10, 4, 3, 13);
    repeat (12) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("cfg_ready_after_abort", {31'b0, cfg_ready}, 32'h1);
    // on_len == 0 completes immediately in every build.
    apply_cfg(16'd6, 0, 2, 2, -1);
    wait_drain("drain_abort", 200);

`ifndef MOD_BURST_SEQ_REPEAT_EN
    // 4: count == 0 completes immediately without repetition.
    busy_cycles = 0;
    apply_cfg(16'd8, 5, 1, 0, -1);
    wait_drain("drain_count0", 50);
    check("busy_cycles_count0", busy_cycles, 32'd0);
`else
    // 4: count == 0 repeats. Observe 20 periods of 3 on / 2 off, then abort
    // in the first cycle of the 21st burst.
    apply_cfg(16'd8, 3, 2, 0, 102);
    repeat (101) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    wait_drain("drain_repeat", 50);
`endif

    // 5: cfg_valid held with other values while busy. The offer is ignored,
    // and mod_cphp keeps the accepted value 9.
    apply_cfg(16'd9, 4, 3, 2, -1);
    cfg_cphp    = 16'h0055;
    cfg_on_len  = LEN_W'(1);
    cfg_off_len = '0;
    cfg_count   = CNT_W'(1);
    cfg_valid   = 1'b1;
    repeat (5) @(posedge clk);
    #1 cfg_valid = 1'b0;
    wait_drain("drain_held_valid", 100);

    // 6: asynchronous reset in the middle of a burst. The outputs must clear
    // before the next clock edge.
    apply_cfg(16'h0033, 20, 1, 1, -1);
    repeat (5) @(posedge clk);
    #2 n_reset = 1'b0;
    #1;
    check("async_reset_outputs",
          {10'b0, rec(mod_cphp, mod_in, mod_n_reset, busy, done, aborted, 1'b0)}, 32'h0);
    check("async_reset_cfg_ready", {31'b0, cfg_ready}, 32'h1);
    sb.delete();
    @(posedge clk); #1;
    n_reset = 1'b1;
    repeat (3) @(posedge clk);

    // 7: normal operation resumes after the reset.
    busy_cycles = 0;
    apply_cfg(16'd2, 2, 1, 2, -1);
    wait_drain("drain_after_reset", 50);
    check("busy_cycles_after_reset", busy_cycles, 32'd6);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
